fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction-fetch controller for the Minx16 core. It sequences the external program counter by driving its load/increment/data inputs. It issues one read per instruction to instruction memory over a req/gnt + rvalid handshake and hands the fetched word to decode over a valid/ready handshake. It also handles branch redirects, including squashing an in-flight fetch.

Parameters:
AW, 16, address / PC width
DW, 16, instruction width; the PC advances by DW/8 per instruction (byte addressing)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
run  in  1  level; 1 = keep fetching, 0 = stop after current instruction handoff
pc_q  in  AW  current program-counter value
pc_ld  out  1  load program counter from pc_d (combinational)
pc_inc  out  1  advance program counter by DW/8 (combinational)
pc_d  out  AW  load value; equals redirect_addr
mem_req  out  1  read request (Moore, from state)
mem_addr  out  AW  read address; equals pc_q
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  DW  read data
ir  out  DW  fetched instruction (registered)
ir_valid  out  1  ir holds an instruction for decode (registered)
ir_ready  in  1  decode accepts ir
redirect  in  1  branch/jump taken this cycle
redirect_addr  in  AW  target address
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high. While rst=1 the block ignores all other inputs.
- Reset values: state=IDLE, ir=0, ir_valid=0, mem_req=0, pc_ld=0, pc_inc=0, busy=0.
- Program-counter sequencing:
  - pc_ld = redirect.
  - pc_inc = (state==WAIT) & mem_rvalid & ~redirect.
  - pc_ld and pc_inc are never both 1.
- States:
  - IDLE: run=1 -> REQ; otherwise stay.
  - REQ: mem_req=1. mem_gnt=1 -> WAIT; otherwise stay. mem_addr tracks pc_q each cycle until granted.
  - WAIT: awaiting data, no new request. mem_rvalid=1 -> ir<=mem_rdata, ir_valid<=1, pc_inc=1, -> HOLD.
  - HOLD: ir_valid=1, no request.
    - ir_ready=1 -> ir_valid<=0, then REQ if run=1, else IDLE.
    - ir_ready=0 -> hold ir stable.
  - DROP: an outstanding response must be discarded. mem_rvalid=1 -> discard data, -> REQ. No pc_inc.
- Redirect (overrides all other transitions; pc_ld=1 the same cycle, so PC updates next edge):
  - IDLE: PC loaded, stay IDLE.
  - REQ with mem_gnt=0: stay REQ; the next request uses the new PC.
  - REQ with mem_gnt=1: the old address was issued -> DROP.
  - WAIT with mem_rvalid=0 -> DROP.
  - WAIT with mem_rvalid=1: response consumed and discarded, ir_valid stays 0 -> REQ.
  - HOLD: ir_valid<=0 (instruction squashed even if ir_ready=1) -> REQ.
  - DROP: stay DROP; if mem_rvalid=1 the same cycle -> REQ.
  - In every case except IDLE, the run check is skipped: the target is always fetched.
- Latency: with zero-wait memory (gnt in REQ, rvalid next cycle), ir_valid rises 2 cycles after REQ entry. Sustained throughput is 1 instruction per 3 cycles.
- Memory protocol: at most one read outstanding; rvalid outside WAIT/DROP is ignored.
- PC wrap: handled by the external counter (mod 2^AW); no special case here.
- run falling mid-fetch: the current fetch completes and hands off, then IDLE.

Optional Feature:
FETCH_SINGLE_STEP_EN.
- Defined: adds input step (1 bit). In IDLE, step=1 -> REQ for exactly one instruction. After handoff in HOLD, return to IDLE regardless of run; a redirect during a stepped fetch keeps the step pending until an instruction hands off.
- Undefined: no step port; IDLE leaves only on run=1.

Decomposition:
- Shared header fetch_defs.vh: state encodings (IDLE=0, REQ=1, WAIT=2, HOLD=3, DROP=4, 3-bit) and the default AW/DW values.
- No sub-module: the program counter stays a separate instance wired to pc_ld/pc_inc/pc_d/pc_q at core level.

Test Plan:
- Sequential fetch: reset, PC=0x0000, run=1, memory grants immediately with rvalid next cycle -> ir_valid at cycles 2, 5, 8; addresses 0x0000, 0x0002, 0x0004; one pc_inc per fetch.
- Decode backpressure: ir_ready=0 for 5 cycles in HOLD -> ir stable, mem_req=0, no pc_inc; ir_ready=1 -> REQ next cycle.
- Redirect in WAIT, rvalid 3 cycles later: redirect_addr=0x0100 -> pc_ld=1, state DROP, stale data not presented; next mem_addr=0x0100.
- Redirect and rvalid same cycle in WAIT: pc_ld=1, pc_inc=0, ir_valid stays 0, next request at the target.
- Redirect in HOLD with ir_ready=1: ir_valid drops, no handoff counted; fetch resumes at the target.
- Stop and reset mid-fetch: run drops in WAIT -> one instruction handed off, then IDLE, busy=0. Separately, rst=1 in WAIT -> IDLE, ir_valid=0 next cycle; later rvalid ignored. With FETCH_SINGLE_STEP_EN: a step pulse yields exactly one handoff.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the Minx16 instruction-fetch sequencer: default widths and FSM encoding.
package fetch_sequencer_pkg;

    localparam int unsigned FETCH_AW = 16;
    localparam int unsigned FETCH_DW = 16;
    localparam int unsigned STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Minx16 instruction-fetch controller: drives the external PC, issues one memory read per
// instruction, hands words to decode and squashes fetches on redirect. Optional: FETCH_SINGLE_STEP_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned AW = FETCH_AW,
    parameter int unsigned DW = FETCH_DW
) (
    input  logic          clk,
    input  logic          rst,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic          step,
`endif
    input  logic          run,
    input  logic [AW-1:0] pc_q,
    output logic          pc_ld,
    output logic          pc_inc,
    output logic [AW-1:0] pc_d,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] ir,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic          busy
);

    fetch_state_e state;
    fetch_state_e state_nxt;
    logic         ir_load;
    logic         ir_clr;
    logic         start;
    logic         cont;

`ifdef FETCH_SINGLE_STEP_EN
    logic step_active;
    logic step_set;
    logic step_clr;

    // A stepped fetch survives redirects and ends only at the next handoff.
    assign start = run | step;
    assign cont  = run & ~step_active;
`else
    assign start = run;
    assign cont  = run;
`endif

    assign pc_d     = redirect_addr;
    assign mem_addr = pc_q;

    // Next-state and PC control; redirect overrides every other transition.
    always_comb begin
        state_nxt = state;
        pc_ld     = 1'b0;
        pc_inc    = 1'b0;
        ir_load   = 1'b0;
        ir_clr    = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
        step_set  = 1'b0;
        step_clr  = 1'b0;
`endif
        if (!rst) begin
            pc_ld = redirect;
            case (state)
                ST_IDLE: begin
                    if (!redirect && start) begin
                        state_nxt = ST_REQ;
`ifdef FETCH_SINGLE_STEP_EN
                        step_set  = step;
`endif
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) state_nxt = redirect ? ST_DROP : ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        if (redirect) begin
                            state_nxt = ST_REQ;
                        end else begin
                            state_nxt = ST_HOLD;
                            ir_load   = 1'b1;
                            pc_inc    = 1'b1;
                        end
                    end else if (redirect) begin
                        state_nxt = ST_DROP;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        ir_clr    = 1'b1;
                        state_nxt = ST_REQ;
                    end else if (ir_ready) begin
                        ir_clr    = 1'b1;
                        state_nxt = cont ? ST_REQ : ST_IDLE;
`ifdef FETCH_SINGLE_STEP_EN
                        step_clr  = 1'b1;
`endif
                    end
                end
                ST_DROP: begin
                    if (mem_rvalid) state_nxt = ST_REQ;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register with state-decoded outputs registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_req <= (state_nxt == ST_REQ);
            busy    <= (state_nxt != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir       <= '0;
            ir_valid <= 1'b0;
        end else if (ir_load) begin
            ir       <= mem_rdata;
            ir_valid <= 1'b1;
        end else if (ir_clr) begin
            ir_valid <= 1'b0;
        end
    end

`ifdef FETCH_SINGLE_STEP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            step_active <= 1'b0;
        end else if (step_set) begin
            step_active <= 1'b1;
        end else if (step_clr) begin
            step_active <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic against a
// transaction-level model (pending request / in-flight read / held instruction flags).
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        step;
    logic [15:0] pc_q;
    logic        pc_ld;
    logic        pc_inc;
    logic [15:0] pc_d;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        busy;

    fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
`ifdef FETCH_SINGLE_STEP_EN
        .step          (step),
`endif
        .run           (run),
        .pc_q          (pc_q),
        .pc_ld         (pc_ld),
        .pc_inc        (pc_inc),
        .pc_d          (pc_d),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a request waiting for grant, a read in flight (possibly stale), a held instruction.
    logic        m_req, m_fly, m_stale, m_hold, m_step;
    logic [15:0] m_ir;

    // Memory and environment state.
    logic        mp_pend;
    logic [15:0] mp_addr;
    int          mp_cnt;
    int          gnt_pct, lat_min, lat_max, spur_pct;

    int          cyc = 0;
    int          first_req;
    int          n_hand, n_inc, n_req_cnt;
    logic        last_pc_ld, last_pc_inc;
    logic [15:0] q_gnt[$];
    int          hand_cyc[$];
    logic [15:0] hand_ir[$];

    function automatic logic [15:0] memfn(input logic [15:0] a);
        logic [31:0] p;
        p = 32'(a) * 32'h9E37;
        return p[15:0] ^ 16'h5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive memory, compare at negedge, advance model/memory/PC, return at posedge+1.
    task automatic tick();
        logic        n_req, n_fly, n_stale, n_hold, n_step;
        logic [15:0] n_ir;
        logic [15:0] pc_n;
        logic        idle;

        mem_gnt = m_req && !mp_pend && ($urandom_range(0, 99) < 32'(gnt_pct));
        if (mp_pend && mp_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memfn(mp_addr);
        end else if (!mp_pend && ($urandom_range(0, 99) < 32'(spur_pct))) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'($urandom);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
        end

        @(negedge clk);
        chk("mem_req",  32'(mem_req),  32'(m_req));
        chk("busy",     32'(busy),     32'(m_req | m_fly | m_hold));
        chk("ir_valid", 32'(ir_valid), 32'(m_hold));
        chk("ir",       32'(ir),       32'(m_ir));
        chk("mem_addr", 32'(mem_addr), 32'(pc_q));
        chk("pc_d",     32'(pc_d),     32'(redirect_addr));
        chk("pc_ld",    32'(pc_ld),    32'(redirect & ~rst));
        chk("pc_inc",   32'(pc_inc),   32'(m_fly & ~m_stale & mem_rvalid & ~redirect & ~rst));

        last_pc_ld  = pc_ld;
        last_pc_inc = pc_inc;
        if (mem_req && first_req < 0) first_req = cyc;
        if (mem_req) n_req_cnt++;
        if (pc_inc) n_inc++;
        if (mem_gnt) q_gnt.push_back(pc_q);
        if (ir_valid && ir_ready && !redirect && !rst) begin
            n_hand++;
            hand_cyc.push_back(cyc);
            hand_ir.push_back(ir);
        end

        n_req = m_req; n_fly = m_fly; n_stale = m_stale; n_hold = m_hold; n_step = m_step; n_ir = m_ir;
        if (rst) begin
            n_req = 0; n_fly = 0; n_stale = 0; n_hold = 0; n_step = 0; n_ir = '0;
        end else begin
            idle = !(m_req || m_fly || m_hold);
            if (m_fly && mem_rvalid) begin
                n_fly   = 0;
                n_stale = 0;
                if (m_stale || redirect) n_req = 1;
                else begin
                    n_hold = 1;
                    n_ir   = mem_rdata;
                end
            end else if (m_fly && redirect) begin
                n_stale = 1;
            end
            if (m_req && mem_gnt) begin
                n_req   = 0;
                n_fly   = 1;
                n_stale = redirect;
            end
            if (m_hold) begin
                if (redirect) begin
                    n_hold = 0;
                    n_req  = 1;
                end else if (ir_ready) begin
                    n_hold = 0;
                    if (m_step) n_step = 0;
                    else if (run) n_req = 1;
                end
            end
            if (idle && !redirect && (run || step)) begin
                n_req  = 1;
                n_step = step;
            end
        end

        if (mem_rvalid && mp_pend) mp_pend = 1'b0;
        else if (mp_pend) mp_cnt--;
        if (mem_gnt) begin
            mp_pend = 1'b1;
            mp_addr = pc_q;
            mp_cnt  = int'($urandom_range(32'(lat_max), 32'(lat_min))) - 1;
        end

        if (pc_ld) pc_n = pc_d;
        else if (pc_inc) pc_n = pc_q + 16'd2;
        else pc_n = pc_q;

        @(posedge clk);
        #1;
        m_req = n_req; m_fly = n_fly; m_stale = n_stale; m_hold = n_hold; m_step = n_step; m_ir = n_ir;
        pc_q = pc_n;
        cyc++;
    endtask

    // Tick until the model reaches a condition (0: fresh read in flight, 1: holding), bounded.
    task automatic wait_model(input int which, input string nm);
        int  n;
        logic c;
        n = 0;
        c = (which == 0) ? (m_fly && !m_stale) : m_hold;
        while (!c && n < 40) begin
            tick();
            n++;
            c = (which == 0) ? (m_fly && !m_stale) : m_hold;
        end
        chk(nm, 32'(c), 32'd1);
    endtask

    task automatic wait_gnt(input string nm, input logic [15:0] exp_addr);
        int n;
        int sz;
        n  = 0;
        sz = q_gnt.size();
        while (q_gnt.size() == sz && n < 40) begin
            tick();
            n++;
        end
        if (q_gnt.size() == sz) chk({nm, "_timeout"}, 32'd0, 32'd1);
        else chk(nm, 32'(q_gnt[q_gnt.size()-1]), 32'(exp_addr));
    endtask

    initial begin
        int h0;
        int i0;
        logic [15:0] keep;

        rst = 1; run = 0; step = 0; redirect = 1; redirect_addr = 16'h1234; ir_ready = 1;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; pc_q = '0;
        m_req = 0; m_fly = 0; m_stale = 0; m_hold = 0; m_step = 0; m_ir = '0;
        mp_pend = 0; mp_addr = '0; mp_cnt = 0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; spur_pct = 0;
        first_req = -1; n_hand = 0; n_inc = 0; n_req_cnt = 0;
        last_pc_ld = 0; last_pc_inc = 0;

        @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_pc_ld_gated", 32'(pc_ld), 32'd0);
        tick();
        redirect = 0;
        tick();

        // Sequential zero-wait fetch.
        rst = 0; run = 1;
        first_req = -1; n_inc = 0; n_hand = 0;
        q_gnt.delete(); hand_cyc.delete(); hand_ir.delete();
        repeat (10) tick();
        chk("seq_hand_count", 32'(hand_cyc.size()), 32'd3);
        if (hand_cyc.size() == 3) begin
            chk("seq_hand0_cyc", 32'(hand_cyc[0] - first_req), 32'd2);
            chk("seq_hand1_cyc", 32'(hand_cyc[1] - first_req), 32'd5);
            chk("seq_hand2_cyc", 32'(hand_cyc[2] - first_req), 32'd8);
            chk("seq_ir0", 32'(hand_ir[0]), 32'h5A5A);
            chk("seq_ir1", 32'(hand_ir[1]), 32'h6634);
        end
        chk("seq_gnt_count", 32'(q_gnt.size()), 32'd3);
        if (q_gnt.size() == 3) begin
            chk("seq_addr0", 32'(q_gnt[0]), 32'h0000);
            chk("seq_addr1", 32'(q_gnt[1]), 32'h0002);
            chk("seq_addr2", 32'(q_gnt[2]), 32'h0004);
        end
        chk("seq_pc_inc_count", 32'(n_inc), 32'd3);

        // Decode backpressure.
        ir_ready = 0;
        wait_model(1, "bp_reach_hold");
        keep = m_ir;
        n_req_cnt = 0; n_inc = 0;
        repeat (5) tick();
        chk("bp_no_req", 32'(n_req_cnt), 32'd0);
        chk("bp_no_inc", 32'(n_inc), 32'd0);
        chk("bp_ir_stable", 32'(ir), 32'(keep));
        chk("bp_ir_valid", 32'(ir_valid), 32'd1);
        ir_ready = 1;
        tick();
        chk("bp_req_after", 32'(mem_req), 32'd1);
        chk("bp_valid_drop", 32'(ir_valid), 32'd0);

        // Redirect in WAIT, response three cycles later.
        lat_min = 4; lat_max = 4;
        wait_model(0, "rw_reach_wait");
        redirect = 1; redirect_addr = 16'h0100;
        h0 = n_hand;
        tick();
        chk("rw_pc_ld", 32'(last_pc_ld), 32'd1);
        redirect = 0;
        lat_min = 1; lat_max = 1;
        chk("rw_drop_busy", 32'(busy), 32'd1);
        chk("rw_drop_noreq", 32'(mem_req), 32'd0);
        wait_gnt("rw_target_addr", 16'h0100);
        chk("rw_no_stale_hand", 32'(n_hand), 32'(h0));

        // Redirect and response in the same WAIT cycle.
        wait_model(0, "rr_reach_wait");
        redirect = 1; redirect_addr = 16'h0200;
        tick();
        chk("rr_pc_ld", 32'(last_pc_ld), 32'd1);
        chk("rr_pc_inc", 32'(last_pc_inc), 32'd0);
        redirect = 0;
        chk("rr_ir_valid", 32'(ir_valid), 32'd0);
        chk("rr_req", 32'(mem_req), 32'd1);
        wait_gnt("rr_target_addr", 16'h0200);

        // Redirect in HOLD while decode is ready.
        ir_ready = 0;
        wait_model(1, "rh_reach_hold");
        ir_ready = 1; redirect = 1; redirect_addr = 16'h0300;
        h0 = n_hand;
        tick();
        redirect = 0;
        chk("rh_ir_valid", 32'(ir_valid), 32'd0);
        chk("rh_no_hand", 32'(n_hand), 32'(h0));
        wait_gnt("rh_target_addr", 16'h0300);

        // run drops mid-fetch.
        wait_model(0, "st_reach_wait");
        run = 0;
        h0 = n_hand;
        repeat (8) tick();
        chk("st_one_hand", 32'(n_hand - h0), 32'd1);
        chk("st_idle", 32'(busy), 32'd0);

        // Reset in WAIT; the late response must be ignored.
        run = 1; lat_min = 3; lat_max = 3;
        wait_model(0, "rs_reach_wait");
        rst = 1; run = 0;
        tick();
        rst = 0;
        chk("rs_ir_valid", 32'(ir_valid), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        i0 = n_inc;
        repeat (6) tick();
        chk("rs_no_inc", 32'(n_inc), 32'(i0));
        chk("rs_ir_valid_late", 32'(ir_valid), 32'd0);
        chk("rs_busy_late", 32'(busy), 32'd0);

`ifdef FETCH_SINGLE_STEP_EN
        step = 1;
        h0 = n_hand;
        tick();
        step = 0;
        repeat (12) tick();
        chk("step_one_hand", 32'(n_hand - h0), 32'd1);
        chk("step_idle", 32'(busy), 32'd0);
`endif

        // Randomized traffic.
        gnt_pct = 60; lat_min = 1; lat_max = 4; spur_pct = 10;
        for (int k = 0; k < 3000; k++) begin
            rst           = ($urandom_range(0, 99) < 1);
            run           = ($urandom_range(0, 99) < 85);
            redirect      = ($urandom_range(0, 99) < 8);
            redirect_addr = 16'($urandom) & 16'hFFFE;
            ir_ready      = ($urandom_range(0, 99) < 60);
`ifdef FETCH_SINGLE_STEP_EN
            step          = ($urandom_range(0, 99) < 5);
`endif
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
